mac_array_acc: RTL and testbench
================================

MAC_ARRAY_ACC -- requirements
Module: mac_array_acc

Interface
REQ-001 Parameter LANES, default 256, SHALL set the number of MAC lanes.
REQ-002 Parameter TAPS, default 25, SHALL set the bits per lane window (5x5 kernel).
REQ-003 Parameter ACC_W, default 16, SHALL set the per-lane accumulator width; PC_W = clog2(TAPS+1).
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle job-start pulse; sampled in IDLE only.
REQ-007 abort  in  1  cancels the job from any state.
REQ-008 cfg_mode  in  1  0 = XNOR-popcount, 1 = AND-popcount; latched at start.
REQ-009 cfg_taps  in  5  number of active taps (1..TAPS); latched at start.
REQ-010 cfg_passes  in  8  beats to accumulate per result; 0 is treated as 1; latched at start.
REQ-011 cfg_keep_w  in  1  1 = reuse weights for the next tile; latched at start.
REQ-012 lane_en  in  LANES  per-lane enable; latched at start.
REQ-013 w_data  in  TAPS*LANES  weights, lane i at bits [i*TAPS +: TAPS]; w_valid in 1; w_ready out 1.
REQ-014 in_data  in  TAPS*LANES  ifmap windows, same packing; in_valid in 1; in_ready out 1.
REQ-015 psum_out  out  ACC_W*LANES  lane results, lane i at bits [i*ACC_W +: ACC_W]; out_valid out 1; out_ready in 1.
REQ-016 busy  out  1  high when not IDLE; done out 1  one-cycle pulse on the final result handshake.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_W, ACCUM and OUT.
REQ-018 IDLE: start SHALL latch all cfg_* inputs and lane_en, then go to LOAD_W.
REQ-019 LOAD_W: w_ready=1; the w_valid&w_ready handshake SHALL latch every lane's weights, clear the accumulators and beat counter, then go to ACCUM.
REQ-020 ACCUM: in_ready=1; each in_valid&in_ready beat SHALL add, per enabled lane, popcount(f(w,x) & mask) to that lane's accumulator.
REQ-021 The mask SHALL have its low cfg_taps bits set; f is XNOR (mode 0) or AND (mode 1); the popcount is zero-extended from PC_W bits.
REQ-022 Accumulation SHALL be unsigned and saturate at 2^ACC_W-1 (no wrap-around).
REQ-023 Disabled lanes SHALL hold 0 in their accumulator and on psum_out.
REQ-024 On the cfg_passes-th beat the FSM SHALL go to OUT, and out_valid SHALL rise on the next cycle with the final sums (latency 1 cycle from the last beat).
REQ-025 OUT: psum_out and out_valid SHALL stay stable until out_ready; in_ready=0 and w_ready=0.
REQ-026 On the out handshake with cfg_keep_w=1 the block SHALL clear the accumulators and return to ACCUM, keeping the weights; with cfg_keep_w=0 it SHALL pulse done and go to IDLE.
REQ-027 With cfg_keep_w=1, leaving the repeating ACCUM/OUT loop SHALL require abort.
REQ-028 abort SHALL take priority over every other event: the block SHALL go to IDLE the next cycle with accumulators cleared, out_valid=0 and no done pulse.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 The ready outputs SHALL depend on state only, never combinationally on the valid inputs.
REQ-031 cfg_taps of 0 SHALL be treated as 1, and values above TAPS as TAPS.

Reset
REQ-032 rst SHALL force IDLE and clear all accumulators, weights, latched config and beat counter.
REQ-033 While rst is high: busy=0, done=0, w_ready=0, in_ready=0, out_valid=0 and psum_out=0.
REQ-034 rst SHALL override abort and start and may occur in any state, including OUT with a result pending (the result is discarded).

Structure
REQ-035 A shared package SHALL hold the state enum, the mode encodings (MODE_XNOR=0, MODE_AND=1) and the popcount-width function.
REQ-036 One sub-module, mac_acc_lane, SHALL implement a single lane: weight register, masked XNOR/AND, popcount and saturating accumulator. It is instantiated LANES times by a generate loop.
REQ-037 The FSM, beat counter and handshakes SHALL live in the top level only.

Verification
REQ-038 Case: LANES=4, mode 0, taps=25, passes=3, w=all-ones, x=all-ones for 3 beats -> each lane psum_out=75, out_valid 1 cycle after the 3rd beat, then done.
REQ-039 Case: mode 1, taps=9, w=0x1FFFFFF, x=0x1FFFFFF, passes=1 -> psum_out=9 per lane; lane_en=4'b0101 -> lanes 1 and 3 read 0.
REQ-040 Case: ACC_W=6, mode 0, taps=25, passes=4 with all-match data -> psum_out saturates at 63, not 100 mod 64.
REQ-041 Case: out_ready held low 10 cycles in OUT -> psum_out stable and in_ready=0 throughout; keep_w=1 -> the next tile accumulates from 0 with the old weights.
REQ-042 Case: abort mid-ACCUM after 1 of 3 beats, then a new start -> IDLE next cycle, no done; the new job result is unaffected by the aborted beats.
REQ-043 Case: rst asserted in OUT with out_valid=1 -> out_valid=0, busy=0 and psum_out=0 on the next edge.

Source files
------------

// File: rtl/mac_array_acc_pkg.sv
// Shared definitions for the binary MAC array: FSM state encoding, the
// popcount operation selector and the popcount width helper.
package mac_array_acc_pkg;

  // Job sequencer states (kept in the package so the top and benches agree).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  // Per-tap combine function applied before the popcount.
  localparam logic MODE_XNOR = 1'b0;
  localparam logic MODE_AND  = 1'b1;

  // Bits needed to hold a popcount of 0..taps.
  function automatic int pc_width(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/mac_array_acc_lane.sv
// One MAC lane: weight register, masked XNOR/AND, popcount and an unsigned
// saturating accumulator. A disabled lane is pinned to zero.
module mac_acc_lane
  import mac_array_acc_pkg::*;
#(
  parameter int TAPS  = 25,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_w,
  input  logic [TAPS-1:0]  i_w,
  input  logic             i_clr,
  input  logic             i_beat,
  input  logic [TAPS-1:0]  i_x,
  input  logic             i_mode,
  input  logic [TAPS-1:0]  i_mask,
  input  logic             i_en,
  output logic [ACC_W-1:0] o_acc
);

  localparam int PC_W  = pc_width(TAPS);
  localparam int SUM_W = ACC_W + PC_W;
  localparam logic [SUM_W-1:0] ACC_MAX = {{PC_W{1'b0}}, {ACC_W{1'b1}}};

  logic [TAPS-1:0]  r_w;
  logic [ACC_W-1:0] r_acc;
  logic [TAPS-1:0]  w_bits;
  logic [PC_W-1:0]  w_pc;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_next;

  // Combine weights and window, then drop taps beyond the active count.
  always_comb begin
    w_bits = '0;
    if (i_mode == MODE_AND) begin
      w_bits = (r_w & i_x) & i_mask;
    end else begin
      w_bits = ~(r_w ^ i_x) & i_mask;
    end
  end

  // Popcount of the masked taps.
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_pc = w_pc + PC_W'(w_bits[i]);
    end
  end

  // Widened add so the carry is visible; clamp instead of wrapping.
  always_comb begin
    w_sum      = {{PC_W{1'b0}}, r_acc} + {{ACC_W{1'b0}}, w_pc};
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_sum > ACC_MAX) begin
      w_acc_next = '1;
    end
  end

  // Weight register, loaded once per job on the weight handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w <= '0;
    end else if (i_load_w) begin
      r_w <= i_w;
    end
  end

  // Accumulator: clear wins over accumulate; disabled lanes stay at zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en) begin
      r_acc <= '0;
    end else if (i_beat) begin
      r_acc <= w_acc_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_array_acc.sv
// Binary MAC array job sequencer: latches a job configuration, loads one
// weight beat, accumulates cfg_passes input beats per tile across all lanes
// and presents the per-lane sums on a valid/ready output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; config and lane enables latched on start
// ST_LOAD_W | w_ready high; weight beat loads lanes and clears sums
// ST_ACCUM  | in_ready high; each beat adds masked popcounts per lane
// ST_OUT    | out_valid high; sums held until out_ready
module mac_array_acc
  import mac_array_acc_pkg::*;
#(
  parameter int LANES = 256,
  parameter int TAPS  = 25,
  parameter int ACC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_mode,
  input  logic [4:0]             cfg_taps,
  input  logic [7:0]             cfg_passes,
  input  logic                   cfg_keep_w,
  input  logic [LANES-1:0]       lane_en,
  input  logic [TAPS*LANES-1:0]  w_data,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [TAPS*LANES-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_W*LANES-1:0] psum_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  state_e             r_state;
  logic               r_mode;
  logic [4:0]         r_taps;
  logic [7:0]         r_passes;
  logic               r_keep_w;
  logic [LANES-1:0]   r_lane_en;
  logic [7:0]         r_beats_left;

  logic [4:0]             w_taps_eff;
  logic [7:0]             w_passes_eff;
  logic [TAPS-1:0]        w_mask;
  logic                   w_w_hs;
  logic                   w_in_hs;
  logic                   w_out_hs;
  logic                   w_lane_load;
  logic                   w_lane_beat;
  logic                   w_acc_clr;
  logic [ACC_W*LANES-1:0] w_psum;

  // Clamp the requested tap count into 1..TAPS and treat zero passes as one.
  always_comb begin
    w_taps_eff = cfg_taps;
    if (cfg_taps == 5'd0) begin
      w_taps_eff = 5'd1;
    end else if (int'(cfg_taps) > TAPS) begin
      w_taps_eff = 5'(TAPS);
    end
    w_passes_eff = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
  end

  // Thermometer mask with the low r_taps bits set.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_mask[i] = (i < int'(r_taps));
    end
  end

  // Handshakes are qualified by state only; abort suppresses any lane update.
  always_comb begin
    w_w_hs      = (r_state == ST_LOAD_W) && w_valid;
    w_in_hs     = (r_state == ST_ACCUM) && in_valid;
    w_out_hs    = (r_state == ST_OUT) && out_ready;
    w_lane_load = w_w_hs && !abort;
    w_lane_beat = w_in_hs && !abort;
    w_acc_clr   = abort || w_w_hs || (w_out_hs && r_keep_w);
  end

  // Job sequencer with a down-counting beat budget per tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_XNOR;
      r_taps       <= '0;
      r_passes     <= '0;
      r_keep_w     <= 1'b0;
      r_lane_en    <= '0;
      r_beats_left <= '0;
    end else if (abort) begin
      r_state      <= ST_IDLE;
      r_beats_left <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode    <= cfg_mode;
            r_taps    <= w_taps_eff;
            r_passes  <= w_passes_eff;
            r_keep_w  <= cfg_keep_w;
            r_lane_en <= lane_en;
            r_state   <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (w_valid) begin
            r_beats_left <= r_passes;
            r_state      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            r_beats_left <= r_beats_left - 8'd1;
            if (r_beats_left == 8'd1) begin
              r_state <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (r_keep_w) begin
              r_beats_left <= r_passes;
              r_state      <= ST_ACCUM;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lane array; every lane shares the control strobes and latched config.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_acc_lane #(
      .TAPS  (TAPS),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_load_w (w_lane_load),
      .i_w      (w_data[g*TAPS +: TAPS]),
      .i_clr    (w_acc_clr),
      .i_beat   (w_lane_beat),
      .i_x      (in_data[g*TAPS +: TAPS]),
      .i_mode   (r_mode),
      .i_mask   (w_mask),
      .i_en     (r_lane_en[g]),
      .o_acc    (w_psum[g*ACC_W +: ACC_W])
    );
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  always_comb begin
    busy      = !rst && (r_state != ST_IDLE);
    w_ready   = !rst && (r_state == ST_LOAD_W);
    in_ready  = !rst && (r_state == ST_ACCUM);
    out_valid = !rst && (r_state == ST_OUT);
    done      = !rst && !abort && w_out_hs && !r_keep_w;
    psum_out  = rst ? '0 : w_psum;
  end

endmodule

// File: tb/tb_mac_array_acc.sv
module tb_mac_array_acc;
  import mac_array_acc_pkg::*;

  localparam int LANES = 4;
  localparam int TAPS  = 25;
  localparam int ACC_A = 16;
  localparam int ACC_B = 6;
  localparam int TW    = TAPS * LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic cfg_mode = 1'b0, cfg_keep_w = 1'b0;
  logic [4:0] cfg_taps = '0;
  logic [7:0] cfg_passes = '0;
  logic [LANES-1:0] lane_en = '0;
  logic [TW-1:0] w_data = '0, in_data = '0;
  logic w_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

  logic w_ready_a, in_ready_a, out_valid_a, busy_a, done_a;
  logic w_ready_b, in_ready_b, out_valid_b, busy_b, done_b;
  logic [ACC_A*LANES-1:0] psum_a;
  logic [ACC_B*LANES-1:0] psum_b;

  mac_array_acc #(.LANES(LANES), .TAPS(TAPS), .ACC_W(ACC_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_taps(cfg_taps), .cfg_passes(cfg_passes), .cfg_keep_w(cfg_keep_w),
    .lane_en(lane_en), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready_a),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .psum_out(psum_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a));

  mac_array_acc #(.LANES(LANES), .TAPS(TAPS), .ACC_W(ACC_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_taps(cfg_taps), .cfg_passes(cfg_passes), .cfg_keep_w(cfg_keep_w),
    .lane_en(lane_en), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready_b),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .psum_out(psum_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned s [LANES];
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Job model state
  logic           m_mode;
  int             m_taps;
  int             m_passes;
  logic           m_keep;
  logic [LANES-1:0] m_en;
  logic [TW-1:0]  m_w;
  int unsigned    m_acc [LANES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int w);
    int unsigned m;
    m = (32'd1 << w) - 32'd1;
    return (v > m) ? m : v;
  endfunction

  function automatic int unsigned lane_pc(input logic mode, input int taps,
                                          input logic [TAPS-1:0] w, input logic [TAPS-1:0] x);
    logic [TAPS-1:0] m;
    logic [TAPS-1:0] f;
    m = TAPS'((64'd1 << taps) - 64'd1);
    f = (mode == MODE_AND) ? (w & x) : ~(w ^ x);
    return $countones(f & m);
  endfunction

  function automatic logic [TW-1:0] rand_vec();
    logic [TW-1:0] v;
    for (int i = 0; i < TW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Monitor: pops the expected tile result on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_a && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got out_valid=1, expected no pending result (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        for (int l = 0; l < LANES; l++) begin
          check($sformatf("psum16_lane%0d", l), 64'(psum_a[l*ACC_A +: ACC_A]), 64'(sat(e.s[l], ACC_A)));
          check($sformatf("psum6_lane%0d", l), 64'(psum_b[l*ACC_B +: ACC_B]), 64'(sat(e.s[l], ACC_B)));
        end
        check("done_on_handshake", 64'(done_a), 64'(e.done));
        check("out_valid_acc6", 64'(out_valid_b), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input bit sel_in);
    int budget = 20;
    while (((sel_in ? in_ready_a : w_ready_a) !== 1'b1) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got ready=0 for 20 cycles, expected ready=1", name);
    end
  endtask

  task automatic start_job(input logic mode, input int taps, input int passes,
                           input logic keep, input logic [LANES-1:0] en);
    cfg_mode = mode; cfg_taps = 5'(taps); cfg_passes = 8'(passes);
    cfg_keep_w = keep; lane_en = en; start = 1'b1;
    m_mode   = mode;
    m_taps   = (taps == 0) ? 1 : ((taps > TAPS) ? TAPS : taps);
    m_passes = (passes == 0) ? 1 : passes;
    m_keep   = keep;
    m_en     = en;
    tick();
    start = 1'b0;
    cfg_mode = 1'($urandom); cfg_taps = 5'($urandom); cfg_passes = 8'($urandom);
    cfg_keep_w = 1'($urandom); lane_en = 4'($urandom);
    check("busy_after_start", 64'(busy_a), 64'd1);
  endtask

  task automatic load_w(input logic [TW-1:0] w);
    w_valid = 1'b1;
    w_data  = w;
    wait_ready("w_ready", 1'b0);
    tick();
    w_valid = 1'b0;
    w_data  = rand_vec();
    m_w     = w;
    check("in_ready_without_valid", 64'(in_ready_a), 64'd1);
  endtask

  task automatic do_beat(input logic [TW-1:0] x, input bit last);
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = rand_vec();
      tick();
    end
    in_valid = 1'b1;
    in_data  = x;
    wait_ready("in_ready", 1'b1);
    if (last) check("out_valid_before_last", 64'(out_valid_a), 64'd0);
    tick();
    in_valid = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (m_en[l]) m_acc[l] += lane_pc(m_mode, m_taps, m_w[l*TAPS +: TAPS], x[l*TAPS +: TAPS]);
  endtask

  // Accumulate one tile; the expected result is queued for the monitor.
  task automatic accum_tile(input bit ones, output exp_t e);
    for (int l = 0; l < LANES; l++) m_acc[l] = 0;
    for (int b = 0; b < m_passes; b++)
      do_beat(ones ? {TW{1'b1}} : rand_vec(), b == m_passes - 1);
    for (int l = 0; l < LANES; l++) e.s[l] = m_acc[l];
    e.done = !m_keep;
    check("out_valid_latency", 64'(out_valid_a), 64'd1);
  endtask

  task automatic finish_tile(input exp_t e, input int stall);
    for (int s = 0; s < stall; s++) begin
      check("stall_in_ready", 64'(in_ready_a), 64'd0);
      check("stall_w_ready", 64'(w_ready_a), 64'd0);
      for (int l = 0; l < LANES; l++)
        check($sformatf("stall_psum_lane%0d", l), 64'(psum_a[l*ACC_A +: ACC_A]), 64'(sat(e.s[l], ACC_A)));
      start = (s == 0);
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_job(input logic mode, input int taps, input int passes, input logic keep,
                         input logic [LANES-1:0] en, input logic [TW-1:0] w, input int tiles,
                         input bit ones, input int stall);
    exp_t e;
    start_job(mode, taps, passes, keep, en);
    load_w(w);
    for (int t = 0; t < tiles; t++) begin
      accum_tile(ones, e);
      exp_q.push_back(e);
      finish_tile(e, stall);
    end
    if (keep) begin
      check("keep_loop_busy", 64'(busy_a), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    check("idle_after_job", 64'(busy_a), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset behaviour
    repeat (2) tick();
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_w_ready", 64'(w_ready_a), 64'd0);
    check("rst_in_ready", 64'(in_ready_a), 64'd0);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_psum", 64'(psum_a != '0), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_w_ready", 64'(w_ready_a), 64'd0);

    // All-match XNOR, 3 beats: 75 per lane (63 on the 6-bit array)
    run_job(MODE_XNOR, 25, 3, 1'b0, 4'b1111, {TW{1'b1}}, 1, 1'b1, 0);
    // AND over 9 taps with lanes 1 and 3 disabled
    run_job(MODE_AND, 9, 1, 1'b0, 4'b0101, {TW{1'b1}}, 1, 1'b1, 1);
    // Four all-match beats: 100, saturating at 63 on the 6-bit array
    run_job(MODE_XNOR, 25, 4, 1'b0, 4'b1111, {TW{1'b1}}, 1, 1'b1, 0);
    // Long stall and weight reuse across tiles
    run_job(MODE_XNOR, 25, 2, 1'b1, 4'b1111, rand_vec(), 2, 1'b0, 10);

    // Abort after one of three beats, then a fresh job
    start_job(MODE_XNOR, 25, 3, 1'b0, 4'b1111);
    load_w({TW{1'b1}});
    do_beat({TW{1'b1}}, 1'b0);
    abort = 1'b1;
    check("abort_no_done", 64'(done_a), 64'd0);
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_out_valid", 64'(out_valid_a), 64'd0);
    check("abort_psum_cleared", 64'(psum_a), 64'd0);
    run_job(MODE_AND, 25, 3, 1'b0, 4'b1111, rand_vec(), 1, 1'b0, 0);

    // Reset while a result is pending in OUT
    start_job(MODE_XNOR, 25, 2, 1'b0, 4'b1111);
    load_w(rand_vec());
    accum_tile(1'b0, e);
    rst = 1'b1;
    tick();
    check("rst_out_valid_in_out", 64'(out_valid_a), 64'd0);
    check("rst_busy_in_out", 64'(busy_a), 64'd0);
    check("rst_psum_in_out", 64'(psum_a), 64'd0);
    check("rst_done_in_out", 64'(done_a), 64'd0);
    rst = 1'b0;
    tick();
    check("after_rst_idle", 64'(busy_a), 64'd0);

    // Randomised jobs, including out-of-range taps and zero passes
    for (int j = 0; j < 16; j++) begin
      logic k;
      k = 1'($urandom);
      run_job(1'($urandom), $urandom_range(0, 31), $urandom_range(0, 5), k,
              4'($urandom), rand_vec(), k ? $urandom_range(1, 3) : 1, 1'b0,
              $urandom_range(0, 3));
    end

    repeat (2) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
